// File: rtl/alu_seq_pkg.sv
// Shared encodings for the sequential ALU with 7-segment readout:
// op codes, FSM state codes and the hex-to-segment decoder.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CALC = 1'b1;

  // Segment vectors are ordered {a,b,c,d,e,f,g}, active-low.
  localparam logic [6:0] SEG_E = 7'b0110000;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/alu_seq_display_if.sv
// Operation request / result bus between a requester and the sequential ALU.
interface alu_seq_display_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     in1;
  logic [WIDTH-1:0]     in2;
  logic [1:0]           op;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 zero;
  logic                 error;

  modport master (
    output start, in1, in2, op,
    input  busy, done, result, zero, error
  );

  modport slave (
    input  start, in1, in2, op,
    output busy, done, result, zero, error
  );
endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed hex display: walks one active-low digit enable per
// SCAN_DIV cycles and drives the matching nibble's segment pattern.
module seg7_scan
  import alu_seq_pkg::*;
#(
  parameter int unsigned NDIG     = 4,
  parameter int unsigned SCAN_DIV = 1024,
  parameter int unsigned RW       = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [RW-1:0]   i_result,
  input  logic            i_error,
  output logic [NDIG-1:0] o_select_disp,
  output logic [6:0]      o_seg
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned PAD_W = 4 * NDIG;

  logic [CNT_W-1:0] r_cnt;
  logic [DIG_W-1:0] r_dig;
  logic [NDIG-1:0]  r_sel;
  logic [6:0]       r_seg;

  logic             w_wrap;
  logic [DIG_W-1:0] w_dig_nxt;
  logic [PAD_W-1:0] w_padded;
  logic [3:0]       w_nib;

  // Enable and segments are both registered from the upcoming digit index,
  // so they always change together.
  always_comb begin
    w_wrap    = (r_cnt == CNT_W'(SCAN_DIV - 1));
    w_dig_nxt = r_dig;
    if (w_wrap) begin
      w_dig_nxt = (r_dig == DIG_W'(NDIG - 1)) ? '0 : r_dig + DIG_W'(1);
    end
    w_padded = PAD_W'(i_result);
    w_nib    = 4'(w_padded >> {w_dig_nxt, 2'b00});
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_dig <= '0;
      r_sel <= ~NDIG'(1);
      r_seg <= hex_to_seg(4'h0);
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      r_dig <= w_dig_nxt;
      r_sel <= ~(NDIG'(1) << w_dig_nxt);
      r_seg <= i_error ? SEG_E : hex_to_seg(w_nib);
    end
  end

  assign o_select_disp = r_sel;
  assign o_seg         = r_seg;

endmodule

// File: rtl/alu_seq_display.sv
// Sequential ALU (1-cycle add/sub, bit-serial shift-add multiply and
// restoring divide) whose registered result is shown on a scanned display.
module alu_seq_display
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NDIG     = 4,
  parameter int unsigned SCAN_DIV = 1024
) (
  input  logic            mclk,
  input  logic            rst,
  alu_seq_display_if.slave bus,
  output logic [NDIG-1:0] select_disp,
  output logic            AE,
  output logic            BE,
  output logic            CE,
  output logic            DE,
  output logic            EE,
  output logic            FE,
  output logic            GE
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  logic [0:0]       r_state;
  logic [RW-1:0]    r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [RW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic [RW-1:0]    r_result;
  logic             r_zero;
  logic             r_error;
  logic             r_done;
  logic             r_busy;

  logic [0:0]       w_state_nxt;
  logic [RW-1:0]    w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [1:0]       w_op_nxt;
  logic [RW-1:0]    w_acc_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [RW-1:0]    w_result_nxt;
  logic             w_zero_nxt;
  logic             w_error_nxt;
  logic             w_done_nxt;
  logic             w_finish;
  logic [RW-1:0]    w_res;
  logic             w_err;

  logic             w_last;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [RW-1:0]    w_prod;
  logic [WIDTH:0]   w_rsh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_quo;
  logic [6:0]       w_seg;

  // Per-cycle datapath: r_a holds the shifting multiplicand or the
  // dividend/quotient register, r_acc the partial product or remainder.
  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_sum  = {1'b0, r_a[WIDTH-1:0]} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a[WIDTH-1:0]} - {1'b0, r_b};
  assign w_prod = r_acc + (r_b[0] ? r_a : '0);
  assign w_rsh  = {r_acc[WIDTH-1:0], r_a[WIDTH-1]};
  assign w_ge   = (w_rsh >= {1'b0, r_b});
  assign w_rem  = WIDTH'(w_ge ? w_rsh - {1'b0, r_b} : w_rsh);
  assign w_quo  = {r_a[WIDTH-2:0], w_ge};

  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_op_nxt     = r_op;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_zero_nxt   = r_zero;
    w_error_nxt  = r_error;
    w_done_nxt   = 1'b0;
    w_finish     = 1'b0;
    w_res        = '0;
    w_err        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_CALC;
          w_a_nxt     = RW'(bus.in1);
          w_b_nxt     = bus.in2;
          w_op_nxt    = bus.op;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      end
      ST_CALC: begin
        w_cnt_nxt = r_cnt + CW'(1);
        case (r_op)
          OP_ADD: begin
            w_finish = 1'b1;
            w_res    = RW'(w_sum);
          end
          OP_SUB: begin
            w_finish = 1'b1;
            w_res    = {{(WIDTH - 1){w_diff[WIDTH]}}, w_diff};
          end
          OP_MUL: begin
            w_acc_nxt = w_prod;
            w_a_nxt   = r_a << 1;
            w_b_nxt   = r_b >> 1;
            w_finish  = w_last;
            w_res     = w_prod;
          end
          default: begin
            // Divide by zero short-circuits on the first CALC cycle.
            if (r_b == '0) begin
              w_finish = 1'b1;
              w_err    = 1'b1;
            end else begin
              w_acc_nxt = RW'(w_rem);
              w_a_nxt   = RW'(w_quo);
              w_finish  = w_last;
              w_res     = {w_rem, w_quo};
            end
          end
        endcase
        if (w_finish) begin
          w_state_nxt  = ST_IDLE;
          w_done_nxt   = 1'b1;
          w_result_nxt = w_res;
          w_zero_nxt   = (w_res == '0);
          w_error_nxt  = w_err;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_error  <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_op     <= w_op_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
      r_zero   <= w_zero_nxt;
      r_error  <= w_error_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= (w_state_nxt == ST_CALC);
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.zero   = r_zero;
  assign bus.error  = r_error;

  seg7_scan #(
    .NDIG     (NDIG),
    .SCAN_DIV (SCAN_DIV),
    .RW       (RW)
  ) u_scan (
    .i_clk         (mclk),
    .i_rst         (rst),
    .i_result      (r_result),
    .i_error       (r_error),
    .o_select_disp (select_disp),
    .o_seg         (w_seg)
  );

  assign {AE, BE, CE, DE, EE, FE, GE} = w_seg;

endmodule

// File: tb/tb_alu_seq_display.sv
// Directed and randomized checks of alu_seq_display against an arithmetic
// reference model (WIDTH=8, NDIG=4, SCAN_DIV=4).
module tb_alu_seq_display;

  logic       mclk;
  logic       rst;
  logic [3:0] select_disp;
  logic       AE, BE, CE, DE, EE, FE, GE;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_res;
  logic        exp_zero;
  logic        exp_err;

  alu_seq_display_if #(.WIDTH(8)) bus ();

  alu_seq_display #(
    .WIDTH    (8),
    .NDIG     (4),
    .SCAN_DIV (4)
  ) dut (
    .mclk        (mclk),
    .rst         (rst),
    .bus         (bus),
    .select_disp (select_disp),
    .AE          (AE),
    .BE          (BE),
    .CE          (CE),
    .DE          (DE),
    .EE          (EE),
    .FE          (FE),
    .GE          (GE)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Standard active-low hex patterns, ordered {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
            7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    return tbl[n];
  endfunction

  function automatic void model(input logic [1:0] op, input int a, input int b,
                                output logic [15:0] res, output int lat, output logic err);
    err = 1'b0;
    lat = 1;
    res = '0;
    case (op)
      2'd0: res = 16'(a + b);
      2'd1: res = 16'(a - b);
      2'd2: begin res = 16'(a * b); lat = 8; end
      default: begin
        if (b == 0) err = 1'b1;
        else begin res = 16'((a % b) * 256 + a / b); lat = 8; end
      end
    endcase
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit pulse3);
    logic [15:0] r;
    int          lat;
    logic        e;
    int          n;
    bit          got;
    model(op, int'(a), int'(b), r, lat, e);
    bus.start = 1'b1; bus.in1 = a; bus.in2 = b; bus.op = op;
    @(posedge mclk); #1;
    bus.start = 1'b0;
    bus.in1 = 8'($urandom); bus.in2 = 8'($urandom); bus.op = 2'($urandom);
    check("busy_after_accept", 32'(bus.busy), 1);
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      if (pulse3 && n == 2) begin
        bus.start = 1'b1; bus.op = 2'd0; bus.in1 = 8'd1; bus.in2 = 8'd1;
      end
      @(posedge mclk); #1;
      bus.start = 1'b0;
      n++;
      if (bus.done) got = 1'b1;
      else check("result_hold", 32'(bus.result), 32'(exp_res));
    end
    exp_res  = r;
    exp_err  = e;
    exp_zero = (r == 16'h0);
    check("done_seen", 32'(got), 1);
    check("latency", 32'(n), 32'(lat));
    check("result", 32'(bus.result), 32'(exp_res));
    check("zero", 32'(bus.zero), 32'(exp_zero));
    check("error", 32'(bus.error), 32'(exp_err));
    check("busy_at_done", 32'(bus.busy), 0);
    if (pulse3) begin
      @(posedge mclk); #1;
      check("done_one_cycle", 32'(bus.done), 0);
      check("no_extra_accept", 32'(bus.busy), 0);
    end
  endtask

  task automatic check_display(input int ncyc);
    int         idx;
    logic [3:0] nib;
    logic [6:0] exp_seg;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge mclk); #1;
      idx = 0;
      for (int i = 0; i < 4; i++) if (select_disp[i] == 1'b0) idx = i;
      check("sel_onehot", 32'($countones(select_disp)), 3);
      nib = 4'(exp_res >> (4 * idx));
      exp_seg = exp_err ? 7'b0110000 : seg_ref(nib);
      check("segments", 32'({AE, BE, CE, DE, EE, FE, GE}), 32'(exp_seg));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.in1 = '0; bus.in2 = '0; bus.op = '0;
    exp_res = '0; exp_zero = 1'b1; exp_err = 1'b0;

    repeat (2) @(posedge mclk);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_result", 32'(bus.result), 0);
    check("rst_zero", 32'(bus.zero), 1);
    check("rst_error", 32'(bus.error), 0);
    check("rst_select", 32'(select_disp), 32'h0E);
    check("rst_segments", 32'({AE, BE, CE, DE, EE, FE, GE}), 32'h01);
    rst = 1'b0;

    // Scan walk: digit index advances every 4 cycles.
    for (int j = 1; j < 20; j++) begin
      logic [3:0] exp_sel;
      @(posedge mclk); #1;
      exp_sel = ~(4'b0001 << ((j / 4) % 4));
      check("scan_select", 32'(select_disp), 32'(exp_sel));
    end

    do_op(2'd0, 8'd200, 8'd100, 1'b0);
    check_display(16);
    do_op(2'd1, 8'd5, 8'd7, 1'b0);
    do_op(2'd1, 8'd9, 8'd9, 1'b0);
    do_op(2'd2, 8'd15, 8'd17, 1'b1);
    do_op(2'd3, 8'd100, 8'd7, 1'b0);
    check_display(16);
    do_op(2'd3, 8'd4, 8'd0, 1'b0);
    check_display(16);
    do_op(2'd2, 8'd12, 8'd11, 1'b0);

    // Reset in the middle of a division aborts it.
    bus.start = 1'b1; bus.in1 = 8'd100; bus.in2 = 8'd7; bus.op = 2'd3;
    @(posedge mclk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge mclk);
    #1;
    rst = 1'b1;
    @(posedge mclk); #1;
    rst = 1'b0;
    exp_res = '0; exp_zero = 1'b1; exp_err = 1'b0;
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_done", 32'(bus.done), 0);
    check("midrst_result", 32'(bus.result), 0);
    check("midrst_zero", 32'(bus.zero), 1);
    check("midrst_error", 32'(bus.error), 0);
    do_op(2'd0, 8'd3, 8'd4, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic [1:0] rop;
      logic [7:0] ra;
      logic [7:0] rb;
      rop = 2'($urandom_range(0, 3));
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      do_op(rop, ra, rb, 1'b0);
      if (t % 10 == 9) check_display(16);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_display.md
ALU_SEQ_DISPLAY -- requirements
Module: alu_seq_display

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, at least 2.
REQ-002 Parameter NDIG, default 4: number of multiplexed 7-segment digits, at least 1.
REQ-003 Parameter SCAN_DIV, default 1024: mclk cycles per digit slot, at least 2.
REQ-004 mclk  in  1: single clock; all state changes on its rising edge.
REQ-005 rst  in  1: reset, synchronous, active-high.
REQ-006 start  in  1: request an operation; sampled only in IDLE.
REQ-007 in1, in2  in  WIDTH each: unsigned operands.
REQ-008 op  in  2: operation code; 00 add, 01 sub, 10 mul, 11 div.
REQ-009 busy  out  1: high while an operation is in progress.
REQ-010 done  out  1: one-cycle pulse when result, zero and error update.
REQ-011 result  out  2*WIDTH: registered result.
REQ-012 zero  out  1: result equals 0.
REQ-013 error  out  1: last operation was a divide by zero.
REQ-014 select_disp  out  NDIG: digit enable, active-low one-hot.
REQ-015 AE, BE, CE, DE, EE, FE, GE  out  1 each: segments a–g, active-low.

Function
REQ-016 The block SHALL have states IDLE and CALC.
- IDLE→CALC: start=1 at an edge in IDLE; that edge latches in1, in2 and op, and busy=1 from the next cycle.
- CALC→IDLE: when the operation completes.
REQ-017 start while busy=1 SHALL be ignored, with no effect on state or latched operands.
REQ-018 Add SHALL produce the zero-extended sum; the carry lands in result[WIDTH].
REQ-019 Sub SHALL produce in1−in2, sign-extended to 2*WIDTH bits.
REQ-020 Add and sub SHALL take one CALC cycle: start accepted at edge k gives result and done=1 after edge k+1.
REQ-021 Mul SHALL be iterative shift-add, one bit per cycle, producing the full 2*WIDTH product; done=1 after edge k+WIDTH.
REQ-022 Div SHALL be restoring, one bit per cycle.
- Output: result[WIDTH-1:0] = quotient, result[2*WIDTH-1:WIDTH] = remainder.
- done=1 after edge k+WIDTH.
REQ-023 Div with in2=0 SHALL complete after edge k+1 with result=0 and error=1.
REQ-024 result, zero and error SHALL change only on the done edge; intermediate datapath values SHALL never appear on them.
REQ-025 error SHALL hold until the next completed operation.
REQ-026 busy SHALL fall on the same edge that raises done; a start in the cycle where done=1 SHALL be accepted.
REQ-027 A scan counter SHALL count 0..SCAN_DIV−1 and wrap.
- Each wrap advances the digit index, which wraps from NDIG−1 to 0.
REQ-028 Digit i SHALL display the hex value of result[4i+3:4i], zero-padded beyond 2*WIDTH bits, using standard 0–F segment patterns.
REQ-029 While error=1, every digit SHALL show "E" (a, d, e, f, g lit).

Reset
REQ-030 rst=1 SHALL force the following at the next edge, including mid-operation, which aborts the operation:
- IDLE, busy=0, done=0, result=0, zero=1, error=0.
- Scan counter 0 and digit index 0, so select_disp = all ones except bit0=0.
- Segments showing "0": AE..FE=0, GE=1.
REQ-031 rst SHALL have priority over start.

Structure
REQ-032 Package alu_seq_pkg SHALL hold the op encodings, the state enumeration and the hex-to-7-segment function, including the "E" pattern.
REQ-033 Digit scanning and segment decode SHALL be the sub-module seg7_scan, parametrised by NDIG and SCAN_DIV.

Verification (WIDTH=8, NDIG=4, SCAN_DIV=4)
REQ-034 Add 200+100 -> result=0x012C with done one cycle after acceptance, zero=0.
REQ-035 Sub 5−7 -> result=0xFFFE; then sub 9−9 -> result=0, zero=1.
REQ-036 Mul 15×17 -> result=0x00FF and done exactly 8 cycles after acceptance; start pulsed at cycle 3 of the multiply is ignored.
REQ-037 Div 100/7 -> result=0x020E. Div 4/0 -> error=1, result=0, done after 1 cycle, and all digits show "E" (AE..GE = 0,1,1,0,0,0,0).
REQ-038 Scan -> select_disp steps 1110, 1101, 1011, 0111, 1110 with 4 cycles per step.
REQ-039 rst asserted at cycle 4 of a division -> next cycle busy=0, result=0, zero=1, and a subsequent add is accepted normally.
